// File: rtl/bool_lut_sweeper_pkg.sv
// Shared constants for the truth-table sweeper: FSM encoding,
// LUT width helper and the default truth table.
package bool_lut_sweeper_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // F = z | (~x & y) over index {w,x,y,z}
    localparam logic [15:0] LUT_INIT_DEFAULT = 16'hAEAE;

    function automatic int unsigned lut_width(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/bool_lut_sweeper_counter.sv
// Exhaustive-sweep index counter with synchronous clear, enable
// and terminal-count flag (high when idx is all ones).
module sweep_counter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [N-1:0] idx_o,
    output logic         tc_o
);

    logic [N-1:0] idx_q;
    logic [N-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (en_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;
    assign tc_o  = &idx_q;

endmodule

// File: rtl/bool_lut_sweeper.sv
// Runtime-loadable N_IN-input truth table with single-shot
// evaluation and an exhaustive sweep that counts minterms.
module bool_lut_sweeper
    import bool_lut_sweeper_pkg::*;
#(
    parameter int unsigned                  N_IN     = 4,
    parameter logic [lut_width(N_IN)-1:0]   LUT_INIT = LUT_INIT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [lut_width(N_IN)-1:0]  cfg_data,
    input  logic                        eval_valid,
    output logic                        eval_ready,
    input  logic [N_IN-1:0]             eval_in,
    input  logic                        sweep_start,
    input  logic                        sweep_abort,
    output logic                        sweep_busy,
    output logic                        sweep_done,
    output logic                        f_valid,
    output logic                        f_out,
    output logic [N_IN-1:0]             f_idx,
    output logic [N_IN:0]               ones_count
);

    localparam int unsigned LUT_W = lut_width(N_IN);
    localparam int unsigned OW    = N_IN + 1;

    logic [LUT_W-1:0] lut_q, lut_d;
    logic [0:0]       state_q, state_d;
    logic             fv_q, fv_d;
    logic             fo_q, fo_d;
    logic [N_IN-1:0]  fi_q, fi_d;
    logic             done_q, done_d;
    logic [N_IN:0]    ones_q, ones_d;

    logic             cnt_clr, cnt_en, cnt_tc;
    logic [N_IN-1:0]  idx;

    sweep_counter #(.N(N_IN)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .idx_o (idx),
        .tc_o  (cnt_tc)
    );

    assign cfg_ready  = (state_q == ST_IDLE);
    assign eval_ready = (state_q == ST_IDLE) & ~sweep_start;
    assign sweep_busy = (state_q == ST_SWEEP);

    always_comb begin
        lut_d   = lut_q;
        state_d = state_q;
        fv_d    = 1'b0;
        fo_d    = fo_q;
        fi_d    = fi_q;
        done_d  = 1'b0;
        ones_d  = ones_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        // single-shot reads lut_q, so a same-cycle load is not yet visible
        if (cfg_valid && cfg_ready) begin
            lut_d = cfg_data;
        end
        if (state_q == ST_IDLE) begin
            if (sweep_start) begin
                state_d = ST_SWEEP;
                cnt_clr = 1'b1;
                ones_d  = '0;
            end else if (eval_valid) begin
                fv_d = 1'b1;
                fo_d = lut_q[eval_in];
                fi_d = eval_in;
            end
        end else if (sweep_abort) begin
            state_d = ST_IDLE;
        end else begin
            fv_d   = 1'b1;
            fo_d   = lut_q[idx];
            fi_d   = idx;
            ones_d = ones_q + OW'(lut_q[idx]);
            cnt_en = ~cnt_tc;
            if (cnt_tc) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lut_q   <= LUT_INIT;
            state_q <= ST_IDLE;
            fv_q    <= 1'b0;
            fo_q    <= 1'b0;
            fi_q    <= '0;
            done_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            lut_q   <= lut_d;
            state_q <= state_d;
            fv_q    <= fv_d;
            fo_q    <= fo_d;
            fi_q    <= fi_d;
            done_q  <= done_d;
            ones_q  <= ones_d;
        end
    end

    assign f_valid    = fv_q;
    assign f_out      = fo_q;
    assign f_idx      = fi_q;
    assign sweep_done = done_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_bool_lut_sweeper.sv
// Directed bench for bool_lut_sweeper with a per-cycle reference
// model plus hand-computed literal checks.
module tb_bool_lut_sweeper;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_data;
    logic        eval_valid;
    logic        eval_ready;
    logic [3:0]  eval_in;
    logic        sweep_start;
    logic        sweep_abort;
    logic        sweep_busy;
    logic        sweep_done;
    logic        f_valid;
    logic        f_out;
    logic [3:0]  f_idx;
    logic [4:0]  ones_count;

    bool_lut_sweeper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .eval_valid  (eval_valid),
        .eval_ready  (eval_ready),
        .eval_in     (eval_in),
        .sweep_start (sweep_start),
        .sweep_abort (sweep_abort),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .f_valid     (f_valid),
        .f_out       (f_out),
        .f_idx       (f_idx),
        .ones_count  (ones_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int c_tests = 0;
    int c_fails = 0;
    bit chk_en = 1'b0;

    // reference model state
    logic [15:0] m_lut = 16'hAEAE;
    bit          m_sweep = 1'b0;
    int          m_pos = 0;
    logic        e_fv = 1'b0;
    logic        e_fo = 1'b0;
    logic [3:0]  e_fi = 4'd0;
    logic        e_done = 1'b0;
    logic [4:0]  e_ones = 5'd0;

    function automatic int prefix_ones(input logic [15:0] t, input int upto);
        int n = 0;
        for (int i = 0; i <= upto; i++) n += int'(t[i]);
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_lut   <= 16'hAEAE;
            m_sweep <= 1'b0;
            m_pos   <= 0;
            e_fv    <= 1'b0;
            e_fo    <= 1'b0;
            e_fi    <= 4'd0;
            e_done  <= 1'b0;
            e_ones  <= 5'd0;
        end else begin
            e_fv   <= 1'b0;
            e_done <= 1'b0;
            if (!m_sweep) begin
                if (cfg_valid) m_lut <= cfg_data;
                if (sweep_start) begin
                    m_sweep <= 1'b1;
                    m_pos   <= 0;
                    e_ones  <= 5'd0;
                end else if (eval_valid) begin
                    e_fv <= 1'b1;
                    e_fo <= m_lut[eval_in];
                    e_fi <= eval_in;
                end
            end else if (sweep_abort) begin
                m_sweep <= 1'b0;
            end else begin
                e_fv   <= 1'b1;
                e_fo   <= m_lut[m_pos];
                e_fi   <= m_pos[3:0];
                e_ones <= 5'(prefix_ones(m_lut, m_pos));
                m_pos  <= m_pos + 1;
                if (m_pos == 15) begin
                    e_done  <= 1'b1;
                    m_sweep <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit bad;
            bad = (f_valid !== e_fv) || (sweep_done !== e_done)
               || (sweep_busy !== m_sweep) || (ones_count !== e_ones)
               || (cfg_ready !== !m_sweep)
               || (eval_ready !== (!m_sweep && !sweep_start))
               || (e_fv && ((f_out !== e_fo) || (f_idx !== e_fi)));
            c_tests++;
            if (bad) begin
                c_fails++;
                $display("FAIL cycle_model t=%0t got v=%b o=%b i=%0d d=%b busy=%b ones=%0d er=%b want v=%b o=%b i=%0d d=%b busy=%b ones=%0d",
                         $time, f_valid, f_out, f_idx, sweep_done, sweep_busy,
                         ones_count, eval_ready, e_fv, e_fo, e_fi, e_done,
                         m_sweep, e_ones);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_done(output int nvalid, output int nones,
                                  output bit ok);
        nvalid = 0;
        nones  = 0;
        ok     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (f_valid) begin
                nvalid++;
                if (f_out) nones++;
            end
            if (sweep_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    int nv, no;
    bit ok;

    initial begin
        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = 16'h0;
        eval_valid  = 1'b0;
        eval_in     = 4'd0;
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_fvalid", 32'(f_valid), 0);
        chk("reset_ones", 32'(ones_count), 0);
        chk("reset_busy", 32'(sweep_busy), 0);

        // 1: default sweep
        step();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        run_until_done(nv, no, ok);
        chk("t1_done_seen", 32'(ok), 1);
        chk("t1_nvalid", 32'(nv), 16);
        chk("t1_ones", 32'(ones_count), 10);
        chk("t1_last_idx", 32'(f_idx), 15);

        // 2: single-shot
        step();
        eval_valid = 1'b1;
        eval_in    = 4'd2;
        step();
        eval_in = 4'd4;
        @(negedge clk);
        chk("t2_e2_out", 32'(f_out), 1);
        chk("t2_e2_idx", 32'(f_idx), 2);
        step();
        eval_in = 4'd1;
        @(negedge clk);
        chk("t2_e4_out", 32'(f_out), 0);
        step();
        eval_in = 4'd8;
        @(negedge clk);
        chk("t2_e1_out", 32'(f_out), 1);
        step();
        eval_valid = 1'b0;
        @(negedge clk);
        chk("t2_e8_out", 32'(f_out), 0);
        chk("t2_e8_idx", 32'(f_idx), 8);
        step();
        @(negedge clk);
        chk("t2_idle_fvalid", 32'(f_valid), 0);

        // 3: load + sweep + blocked eval in one cycle
        step();
        cfg_valid   = 1'b1;
        cfg_data    = 16'h8000;
        sweep_start = 1'b1;
        eval_valid  = 1'b1;
        eval_in     = 4'd15;
        #1;
        chk("t3_eval_ready", 32'(eval_ready), 0);
        step();
        cfg_valid   = 1'b0;
        sweep_start = 1'b0;
        eval_valid  = 1'b0;
        @(negedge clk);
        chk("t3_no_single", 32'(f_valid), 0);
        run_until_done(nv, no, ok);
        chk("t3_done_seen", 32'(ok), 1);
        chk("t3_nvalid", 32'(nv), 16);
        chk("t3_nones", 32'(no), 1);
        chk("t3_ones", 32'(ones_count), 1);
        chk("t3_last_out", 32'(f_out), 1);

        // 4: load and evaluate in the same cycle
        step();
        cfg_valid  = 1'b1;
        cfg_data   = 16'hFFFF;
        eval_valid = 1'b1;
        eval_in    = 4'd0;
        step();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("t4_old_lut", 32'(f_out), 0);
        step();
        eval_valid = 1'b0;
        @(negedge clk);
        chk("t4_new_lut", 32'(f_out), 1);

        // 5: abort after 5 results
        step();
        cfg_valid = 1'b1;
        cfg_data  = 16'hAEAE;
        step();
        cfg_valid   = 1'b0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        repeat (5) step();
        sweep_abort = 1'b1;
        step();
        sweep_abort = 1'b0;
        @(negedge clk);
        chk("t5_fvalid", 32'(f_valid), 0);
        chk("t5_busy", 32'(sweep_busy), 0);
        chk("t5_done", 32'(sweep_done), 0);
        chk("t5_ones", 32'(ones_count), 3);
        repeat (2) step();
        @(negedge clk);
        chk("t5_ones_held", 32'(ones_count), 3);
        step();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        @(negedge clk);
        chk("t5_ones_clear", 32'(ones_count), 0);
        run_until_done(nv, no, ok);
        chk("t5_done_seen", 32'(ok), 1);
        chk("t5_nvalid", 32'(nv), 16);
        chk("t5_ones_full", 32'(ones_count), 10);

        // 6: reset mid-sweep
        step();
        cfg_valid = 1'b1;
        cfg_data  = 16'h0001;
        step();
        cfg_valid   = 1'b0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_fvalid", 32'(f_valid), 0);
        chk("t6_busy", 32'(sweep_busy), 0);
        chk("t6_ones", 32'(ones_count), 0);
        chk("t6_fidx", 32'(f_idx), 0);
        step();
        eval_valid = 1'b1;
        eval_in    = 4'd2;
        step();
        eval_valid = 1'b0;
        @(negedge clk);
        chk("t6_lut_init", 32'(f_out), 1);
        step();
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed",
                 tests + c_tests, fails + c_fails);
        $finish;
    end

endmodule

// File: doc/bool_lut_sweeper.md
Name: bool_lut_sweeper

Overview:
Parametrised successor to the team's fixed gate-level 4-input sum-of-products functions. It evaluates any N_IN-input boolean function held in a runtime-loadable truth-table register.
- Single-shot mode: registered evaluation of one input vector per request.
- Sweep mode: steps through all 2^N_IN input combinations, one per cycle, streaming F and counting minterms.

This gives an on-chip exhaustive check of the function, replacing a testbench-only loop. The block sits between a config/CSR master and a result consumer.

Parameters:
- N_IN, 4: number of function inputs; LUT width is 2**N_IN (local constant LUT_W).
- LUT_INIT, 16'hAEAE: truth table loaded at reset. Bit i = F(i), with index {w,x,y,z}, w = MSB. The default encodes F = z | (~x & y).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  load request for the truth table
- cfg_ready  out  1  high when a load is accepted
- cfg_data  in  LUT_W  new truth table
- eval_valid  in  1  single-shot evaluation request
- eval_ready  out  1  high when a single-shot request is accepted
- eval_in  in  N_IN  input vector for single-shot evaluation
- sweep_start  in  1  begin exhaustive sweep
- sweep_abort  in  1  terminate sweep early
- sweep_busy  out  1  high while in SWEEP
- sweep_done  out  1  one-cycle pulse on the final sweep result
- f_valid  out  1  f_out/f_idx valid this cycle
- f_out  out  1  function value
- f_idx  out  N_IN  input vector that produced f_out
- ones_count  out  N_IN+1  number of 1s seen in the current/last sweep

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - lut <= LUT_INIT, state <= IDLE, idx <= 0.
  - f_valid, f_out, f_idx, sweep_done, ones_count <= 0.
  - Reset takes effect mid-sweep; no sweep_done is produced.
- FSM states are IDLE and SWEEP. sweep_busy = (state==SWEEP).
- Ready signals:
  - cfg_ready = (state==IDLE).
  - eval_ready = (state==IDLE) & ~sweep_start. Sweep has priority over single-shot.
- Config load: on cfg_valid & cfg_ready, lut <= cfg_data at that edge. A single-shot evaluation accepted in the same cycle uses the pre-update lut.
- Single-shot evaluation:
  - On eval_valid & eval_ready, the next cycle has f_valid=1, f_out=lut[eval_in], f_idx=eval_in.
  - Latency is 1 cycle, throughput 1 per cycle.
  - f_valid=0 in any cycle that follows no accepted request.
- IDLE->SWEEP: when sweep_start=1 in IDLE, then idx <= 0 and ones_count <= 0. If cfg is accepted in the same cycle, the sweep uses the new lut. sweep_start is ignored in SWEEP.
- Each SWEEP cycle (no abort):
  - f_valid<=1, f_out<=lut[idx], f_idx<=idx.
  - ones_count <= ones_count + lut[idx].
  - idx <= idx+1.
- SWEEP exit: at idx == 2^N_IN-1, additionally sweep_done<=1 and state<=IDLE.
  - Results occupy exactly 2^N_IN consecutive cycles.
  - sweep_done coincides with the last f_valid, and ones_count is final in that cycle.
- Abort: sweep_abort=1 in SWEEP sends state to IDLE with f_valid<=0 and no sweep_done. ones_count holds its partial value. sweep_abort is ignored in IDLE.
- ones_count holds until the next sweep_start. Its range is 0..2^N_IN; the width N_IN+1 means no overflow.
- idx wrap: idx never increments past 2^N_IN-1, because the terminal cycle leaves SWEEP.

Decomposition:
- Shared package (or include header) holds:
  - state encoding (IDLE=1'b0, SWEEP=1'b1)
  - the LUT_W = 2**N_IN helper
  - default LUT_INIT constant
- One natural sub-module, sweep_counter:
  - N_IN-bit idx counter with clear/enable/terminal-count output.
  - Reused for other exhaustive-sweep blocks.
- The truth-table register, result mux and FSM remain in the top module.

Test Plan:
1. Reset, then sweep_start with default LUT -> 16 f_valid cycles with f_idx 0..15 and f_out matching 16'hAEAE bits; sweep_done on the f_idx=15 cycle; ones_count=10.
2. Single-shot with default LUT:
   - eval_in=4'b0010 -> next cycle f_out=1, f_idx=2.
   - eval_in=4'b0100 -> f_out=0.
   - Back-to-back eval_in=1 then 8 -> f_out 1 then 0 on consecutive cycles.
3. Load then sweep: cfg_data=16'h8000 together with sweep_start -> sweep shows only f_idx=15 with f_out=1; ones_count=1. Same cycle with eval_in=15 -> eval_ready=0, no single-shot result.
4. Load and evaluate in the same cycle: cfg_data=16'hFFFF with eval_in=0 -> f_out reflects the old LUT (0). Next eval_in=0 -> f_out=1.
5. Abort after 5 sweep results with the default LUT -> f_valid drops, sweep_done never pulses, ones_count=3 held, sweep_busy=0; the next sweep_start clears the count and runs the full 16 cycles.
6. Reset mid-sweep after a cfg load of 16'h0001 (rst_n low at result 7) -> all outputs 0, state IDLE; lut restored so that eval_in=2 gives f_out=1 (LUT_INIT).
